// File: rtl/sram_arbiter.sv
// rtl/sram_arbiter.sv - two-requester arbiter for the shared static_ram port
// Define SRAM_ARB_RR_EN for round-robin on simultaneous requests; fixed m0 priority otherwise.
module sram_arbiter #(
  parameter int ADDR_W    = 20,
  parameter int DATA_W    = 48,
  parameter int READ_WAIT = 2
) (
  input  logic              clk100,
  input  logic              rst,
  input  logic              m0_stb_i,
  input  logic              m0_we_i,
  input  logic [ADDR_W-1:0] m0_addr_i,
  input  logic [DATA_W-1:0] m0_din_i,
  output logic [DATA_W-1:0] m0_dout_o,
  output logic              m0_ack_o,
  input  logic              m1_stb_i,
  input  logic              m1_we_i,
  input  logic [ADDR_W-1:0] m1_addr_i,
  input  logic [DATA_W-1:0] m1_din_i,
  output logic [DATA_W-1:0] m1_dout_o,
  output logic              m1_ack_o,
  output logic              s_stb_o,
  output logic              s_we_o,
  output logic [ADDR_W-1:0] s_addr_o,
  output logic [DATA_W-1:0] s_din_o,
  input  logic [DATA_W-1:0] s_dout_i,
  input  logic              s_ack_i,
  output logic [1:0]        grant_o
);

  localparam int CW = (READ_WAIT > 1) ? $clog2(READ_WAIT) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(READ_WAIT - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic                s_we_q, s_we_d;
  logic [ADDR_W-1:0]   s_addr_q, s_addr_d;
  logic [DATA_W-1:0]   s_din_q, s_din_d;
  logic [1:0]          grant_q, grant_d;
  logic                m0_ack_q, m0_ack_d;
  logic                m1_ack_q, m1_ack_d;
  logic [DATA_W-1:0]   m0_dout_q, m0_dout_d;
  logic [DATA_W-1:0]   m1_dout_q, m1_dout_d;
  logic                pick_m1;
  logic                xfer_done;

`ifdef SRAM_ARB_RR_EN
  // last_q=1 means m1 took the last grant, so m0 wins the next contest.
  logic last_q, last_d;

  always_comb begin
    pick_m1 = m1_stb_i && (!m0_stb_i || !last_q);
  end
`else
  always_comb begin
    pick_m1 = m1_stb_i && !m0_stb_i;
  end
`endif

  // Reads must sit for READ_WAIT cycles; writes finish on the controller's ack.
  always_comb begin
    xfer_done = s_we_q ? s_ack_i : ((cnt_q == CNT_MAX) && s_ack_i);
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    s_we_d    = s_we_q;
    s_addr_d  = s_addr_q;
    s_din_d   = s_din_q;
    grant_d   = grant_q;
    m0_ack_d  = 1'b0;
    m1_ack_d  = 1'b0;
    m0_dout_d = m0_dout_q;
    m1_dout_d = m1_dout_q;
`ifdef SRAM_ARB_RR_EN
    last_d    = last_q;
`endif
    case (state_q)
      IDLE: begin
        if (m0_stb_i || m1_stb_i) begin
          grant_d  = pick_m1 ? 2'b10 : 2'b01;
          s_we_d   = pick_m1 ? m1_we_i : m0_we_i;
          s_addr_d = pick_m1 ? m1_addr_i : m0_addr_i;
          s_din_d  = pick_m1 ? m1_din_i : m0_din_i;
          cnt_d    = '0;
          state_d  = BUSY;
`ifdef SRAM_ARB_RR_EN
          last_d   = pick_m1;
`endif
        end
      end
      BUSY: begin
        if (cnt_q != CNT_MAX) begin
          cnt_d = cnt_q + CW'(1);
        end
        if (xfer_done) begin
          state_d  = DONE;
          m0_ack_d = grant_q[0];
          m1_ack_d = grant_q[1];
          if (!s_we_q && grant_q[0]) begin
            m0_dout_d = s_dout_i;
          end
          if (!s_we_q && grant_q[1]) begin
            m1_dout_d = s_dout_i;
          end
        end
      end
      DONE: begin
        grant_d = 2'b00;
        state_d = IDLE;
      end
      default: begin
        grant_d = 2'b00;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk100) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      s_we_q    <= 1'b0;
      s_addr_q  <= '0;
      s_din_q   <= '0;
      grant_q   <= 2'b00;
      m0_ack_q  <= 1'b0;
      m1_ack_q  <= 1'b0;
      m0_dout_q <= '0;
      m1_dout_q <= '0;
`ifdef SRAM_ARB_RR_EN
      last_q    <= 1'b1;
`endif
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      s_we_q    <= s_we_d;
      s_addr_q  <= s_addr_d;
      s_din_q   <= s_din_d;
      grant_q   <= grant_d;
      m0_ack_q  <= m0_ack_d;
      m1_ack_q  <= m1_ack_d;
      m0_dout_q <= m0_dout_d;
      m1_dout_q <= m1_dout_d;
`ifdef SRAM_ARB_RR_EN
      last_q    <= last_d;
`endif
    end
  end

  // Strobe is low in IDLE and DONE, giving the controller its re-idle cycle.
  assign s_stb_o   = (state_q == BUSY);
  assign s_we_o    = s_we_q;
  assign s_addr_o  = s_addr_q;
  assign s_din_o   = s_din_q;
  assign grant_o   = grant_q;
  assign m0_ack_o  = m0_ack_q;
  assign m1_ack_o  = m1_ack_q;
  assign m0_dout_o = m0_dout_q;
  assign m1_dout_o = m1_dout_q;

endmodule

// File: tb/tb_sram_arbiter.sv
// tb/tb_sram_arbiter.sv - directed self-checking bench for sram_arbiter
// Second instance runs with READ_WAIT=4.
module tb_sram_arbiter;

  logic        clk100 = 1'b0;
  logic        rst = 1'b1;
  logic        m0_stb = 1'b0, m0_we = 1'b0;
  logic [19:0] m0_addr = '0;
  logic [47:0] m0_din = '0, m0_dout;
  logic        m0_ack;
  logic        m1_stb = 1'b0, m1_we = 1'b0;
  logic [19:0] m1_addr = '0;
  logic [47:0] m1_din = '0, m1_dout;
  logic        m1_ack;
  logic        s_stb, s_we, s_ack;
  logic [19:0] s_addr;
  logic [47:0] s_din;
  logic [47:0] rd_data = '0;
  logic [1:0]  grant;
  logic [2:0]  wcnt = '0;

  logic        b_m0_stb = 1'b0;
  logic [47:0] b_m0_dout, b_m1_dout, b_s_din;
  logic        b_m0_ack, b_m1_ack, b_s_stb, b_s_we;
  logic [19:0] b_s_addr;
  logic [1:0]  b_grant;
  logic [47:0] b_rd_data = 48'h0000_0000_0000;
  logic        b_s_ack = 1'b1;

  int checks = 0;
  int errors = 0;

  always #5 clk100 = ~clk100;

  // static_ram model: reads ack at once, writes ack on the 6th strobed cycle.
  assign s_ack = s_stb && (!s_we || (wcnt == 3'd5));
  always @(posedge clk100) wcnt <= (s_stb && s_we) ? wcnt + 3'd1 : 3'd0;

  sram_arbiter dut (
    .clk100(clk100), .rst(rst),
    .m0_stb_i(m0_stb), .m0_we_i(m0_we), .m0_addr_i(m0_addr), .m0_din_i(m0_din),
    .m0_dout_o(m0_dout), .m0_ack_o(m0_ack),
    .m1_stb_i(m1_stb), .m1_we_i(m1_we), .m1_addr_i(m1_addr), .m1_din_i(m1_din),
    .m1_dout_o(m1_dout), .m1_ack_o(m1_ack),
    .s_stb_o(s_stb), .s_we_o(s_we), .s_addr_o(s_addr), .s_din_o(s_din),
    .s_dout_i(rd_data), .s_ack_i(s_ack), .grant_o(grant)
  );

  sram_arbiter #(.READ_WAIT(4)) dut4 (
    .clk100(clk100), .rst(rst),
    .m0_stb_i(b_m0_stb), .m0_we_i(1'b0), .m0_addr_i(20'h00040), .m0_din_i(48'h0),
    .m0_dout_o(b_m0_dout), .m0_ack_o(b_m0_ack),
    .m1_stb_i(1'b0), .m1_we_i(1'b0), .m1_addr_i(20'h0), .m1_din_i(48'h0),
    .m1_dout_o(b_m1_dout), .m1_ack_o(b_m1_ack),
    .s_stb_o(b_s_stb), .s_we_o(b_s_we), .s_addr_o(b_s_addr), .s_din_o(b_s_din),
    .s_dout_i(b_rd_data), .s_ack_i(b_s_ack), .grant_o(b_grant)
  );

  task automatic tick;
    @(posedge clk100);
    #1;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (3) tick;
    checks++;
    if ({s_stb, s_we, grant, m0_ack, m1_ack} !== 6'b0) begin
      errors++;
      $display("FAIL reset_ctl got %b exp 000000", {s_stb, s_we, grant, m0_ack, m1_ack});
    end
    checks++;
    if ({s_addr, s_din, m0_dout, m1_dout} !== 164'b0) begin
      errors++;
      $display("FAIL reset_data got %h exp 0", {s_addr, s_din, m0_dout, m1_dout});
    end
    checks++;
    if ({b_s_stb, b_grant, b_m0_ack} !== 4'b0) begin
      errors++;
      $display("FAIL reset_rw4 got %b exp 0000", {b_s_stb, b_grant, b_m0_ack});
    end
    rst = 1'b0;
    tick;
  endtask

  task automatic test_read;
    rd_data = 48'hA5A5_0000_1234;
    m0_we = 1'b0; m0_addr = 20'h00010; m0_stb = 1'b1;
    for (int c = 1; c <= 4; c++) begin
      tick;
      checks++;
      if (m0_ack !== (c == 3)) begin
        errors++;
        $display("FAIL read_ack cycle %0d got %b exp %b", c, m0_ack, (c == 3));
      end
      checks++;
      if (grant !== ((c <= 3) ? 2'b01 : 2'b00)) begin
        errors++;
        $display("FAIL read_grant cycle %0d got %b", c, grant);
      end
      checks++;
      if (s_stb !== (c <= 2)) begin
        errors++;
        $display("FAIL read_sstb cycle %0d got %b exp %b", c, s_stb, (c <= 2));
      end
      if (c == 1) begin
        checks++;
        if ({s_we, s_addr} !== {1'b0, 20'h00010}) begin
          errors++;
          $display("FAIL read_saddr got %b/%h exp 0/00010", s_we, s_addr);
        end
      end
      if (c == 3) begin
        m0_stb = 1'b0;
        checks++;
        if (m0_dout !== 48'hA5A5_0000_1234) begin
          errors++;
          $display("FAIL read_dout got %h exp a5a500001234", m0_dout);
        end
      end
    end
  endtask

  task automatic test_write;
    m1_we = 1'b1; m1_addr = 20'hFFFFF; m1_din = 48'h1; m1_stb = 1'b1;
    for (int c = 1; c <= 8; c++) begin
      tick;
      checks++;
      if (s_stb !== (c >= 1 && c <= 6)) begin
        errors++;
        $display("FAIL write_sstb cycle %0d got %b", c, s_stb);
      end
      checks++;
      if ({m1_ack, m0_ack} !== {(c == 7), 1'b0}) begin
        errors++;
        $display("FAIL write_ack cycle %0d got %b%b", c, m1_ack, m0_ack);
      end
      if (c <= 6) begin
        checks++;
        if ({s_we, s_addr, s_din} !== {1'b1, 20'hFFFFF, 48'h1}) begin
          errors++;
          $display("FAIL write_sbus cycle %0d got %b/%h/%h", c, s_we, s_addr, s_din);
        end
      end
      if (c == 7) m1_stb = 1'b0;
    end
    checks++;
    if (m1_dout !== 48'h0) begin
      errors++;
      $display("FAIL write_dout got %h exp 0", m1_dout);
    end
  endtask

  task automatic test_contention;
    int order[$];
    int ackcyc[$];
    int exp_order[4];
    int n0 = 0, n1 = 0, cyc = 0;
`ifdef SRAM_ARB_RR_EN
    exp_order = '{0, 1, 0, 1};
`else
    exp_order = '{0, 0, 1, 1};
`endif
    rd_data = 48'h0000_BEEF_0001;
    m0_we = 1'b0; m1_we = 1'b0;
    m0_addr = 20'h00100; m1_addr = 20'h00200;
    m0_stb = 1'b1; m1_stb = 1'b1;
    while ((n0 < 2 || n1 < 2) && cyc < 60) begin
      tick;
      cyc++;
      checks++;
      if (m0_ack && m1_ack) begin
        errors++;
        $display("FAIL cont_both_ack cycle %0d got 11 exp one-hot", cyc);
      end
      if (m0_ack || m1_ack) begin
        checks++;
        if (s_stb !== 1'b0) begin
          errors++;
          $display("FAIL cont_done_sstb cycle %0d got %b exp 0", cyc, s_stb);
        end
        ackcyc.push_back(cyc);
        if (m0_ack) begin
          order.push_back(0);
          n0++;
          if (n0 == 2) m0_stb = 1'b0;
        end else begin
          order.push_back(1);
          n1++;
          if (n1 == 2) m1_stb = 1'b0;
        end
      end
    end
    checks++;
    if (order.size() != 4) begin
      errors++;
      $display("FAIL cont_count got %0d acks exp 4", order.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        checks++;
        if (order[i] != exp_order[i]) begin
          errors++;
          $display("FAIL cont_order idx %0d got m%0d exp m%0d", i, order[i], exp_order[i]);
        end
        checks++;
        if (ackcyc[i] != 3 + 4 * i) begin
          errors++;
          $display("FAIL cont_ack_cycle idx %0d got %0d exp %0d", i, ackcyc[i], 3 + 4 * i);
        end
      end
    end
    checks++;
    if ({m0_dout, m1_dout} !== {48'h0000_BEEF_0001, 48'h0000_BEEF_0001}) begin
      errors++;
      $display("FAIL cont_dout got %h/%h", m0_dout, m1_dout);
    end
    tick;
  endtask

  task automatic test_drop;
    rd_data = 48'h1111_2222_3333;
    m0_we = 1'b0; m0_addr = 20'h00020; m0_stb = 1'b1;
    for (int c = 1; c <= 4; c++) begin
      tick;
      if (c == 2) m0_stb = 1'b0;
      checks++;
      if (m0_ack !== (c == 3)) begin
        errors++;
        $display("FAIL drop_ack cycle %0d got %b exp %b", c, m0_ack, (c == 3));
      end
    end
    checks++;
    if (m0_dout !== 48'h1111_2222_3333) begin
      errors++;
      $display("FAIL drop_dout got %h exp 111122223333", m0_dout);
    end
  endtask

  task automatic test_rst_mid;
    m0_we = 1'b1; m0_addr = 20'h00ABC; m0_din = 48'hDEAD; m0_stb = 1'b1;
    repeat (3) tick;
    rst = 1'b1;
    tick;
    checks++;
    if ({s_stb, grant, m0_ack, m1_ack, s_we} !== 6'b0) begin
      errors++;
      $display("FAIL rstmid_ctl got %b exp 000000", {s_stb, grant, m0_ack, m1_ack, s_we});
    end
    checks++;
    if (m0_dout !== 48'h0) begin
      errors++;
      $display("FAIL rstmid_dout got %h exp 0", m0_dout);
    end
    rst = 1'b0;
    m0_stb = 1'b0;
    for (int c = 0; c < 4; c++) begin
      tick;
      checks++;
      if ({m0_ack, s_stb} !== 2'b00) begin
        errors++;
        $display("FAIL rstmid_idle cycle %0d got %b exp 00", c, {m0_ack, s_stb});
      end
    end
    rd_data = 48'h0BAD_F00D_0042;
    m0_we = 1'b0; m0_stb = 1'b1;
    repeat (3) tick;
    checks++;
    if ({m0_ack, m0_dout} !== {1'b1, 48'h0BAD_F00D_0042}) begin
      errors++;
      $display("FAIL rstmid_fresh got %b/%h exp 1/0badf00d0042", m0_ack, m0_dout);
    end
    m0_stb = 1'b0;
    tick;
  endtask

  task automatic test_read_wait4;
    b_rd_data = 48'h4444_0000_0004;
    b_m0_stb = 1'b1;
    for (int c = 1; c <= 6; c++) begin
      tick;
      checks++;
      if (b_s_stb !== (c >= 1 && c <= 4)) begin
        errors++;
        $display("FAIL rw4_sstb cycle %0d got %b", c, b_s_stb);
      end
      checks++;
      if (b_m0_ack !== (c == 5)) begin
        errors++;
        $display("FAIL rw4_ack cycle %0d got %b exp %b", c, b_m0_ack, (c == 5));
      end
      if (c == 5) b_m0_stb = 1'b0;
    end
    checks++;
    if (b_m0_dout !== 48'h4444_0000_0004) begin
      errors++;
      $display("FAIL rw4_dout got %h exp 444400000004", b_m0_dout);
    end
  endtask

  initial begin
    test_reset;
    test_read;
    test_write;
    test_contention;
    test_drop;
    test_rst_mid;
    test_read_wait4;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
